// File: rtl/pipe_ex_hs.sv
// rtl/pipe_ex_hs.sv - three-stage F = ((A+B) + (C -/+ D)) * D pipeline with valid/ready handshake
module pipe_ex_hs #(
    parameter int N     = 10,
    parameter int OUT_W = 2*N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    input  logic [N-1:0]     C,
    input  logic [N-1:0]     D,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] F,
    output logic [1:0]       occupancy
);

    // Stage 1: partial sums and the D operand carried forward
    logic [N-1:0]     x1_q, x1_d;
    logic [N-1:0]     x2_q, x2_d;
    logic [N-1:0]     d1_q, d1_d;
    logic             v1_q, v1_d;

    // Stage 2: combined sum
    logic [N-1:0]     x3_q, x3_d;
    logic [N-1:0]     d2_q, d2_d;
    logic             v2_q, v2_d;

    // Stage 3: product
    logic [OUT_W-1:0] f_q, f_d;
    logic             v3_q, v3_d;

    logic             adv1, adv2, adv3;
    logic [N-1:0]     sum_ab, sum_cd, sum_x;
    logic [2*N-1:0]   x3_ext, d2_ext, prod_full;

    // A stage may advance when it is empty or its successor advances; the
    // ripple from out_ready to in_ready is a deliberate combinational path.
    always_comb begin
        adv3     = !v3_q || out_ready;
        adv2     = !v2_q || adv3;
        adv1     = !v1_q || adv2;
        in_ready = adv1;
    end

    always_comb begin
        sum_ab    = A + B;
        sum_cd    = mode ? (C + D) : (C - D);
        sum_x     = x1_q + x2_q;
        x3_ext    = {{N{1'b0}}, x3_q};
        d2_ext    = {{N{1'b0}}, d2_q};
        prod_full = x3_ext * d2_ext;
    end

    always_comb begin
        x1_d = x1_q;
        x2_d = x2_q;
        d1_d = d1_q;
        v1_d = v1_q;
        x3_d = x3_q;
        d2_d = d2_q;
        v2_d = v2_q;
        f_d  = f_q;
        v3_d = v3_q;

        if (adv1) begin
            x1_d = sum_ab;
            x2_d = sum_cd;
            d1_d = D;
            v1_d = in_valid;
        end

        if (adv2) begin
            x3_d = sum_x;
            d2_d = d1_q;
            v2_d = v1_q;
        end

        if (adv3) begin
            f_d  = prod_full[OUT_W-1:0];
            v3_d = v2_q;
        end

        // Flush only kills valids; stale data behind a zero valid is harmless.
        if (flush) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
            v3_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1_q <= '0;
            x2_q <= '0;
            d1_q <= '0;
            v1_q <= 1'b0;
            x3_q <= '0;
            d2_q <= '0;
            v2_q <= 1'b0;
            f_q  <= '0;
            v3_q <= 1'b0;
        end else begin
            x1_q <= x1_d;
            x2_q <= x2_d;
            d1_q <= d1_d;
            v1_q <= v1_d;
            x3_q <= x3_d;
            d2_q <= d2_d;
            v2_q <= v2_d;
            f_q  <= f_d;
            v3_q <= v3_d;
        end
    end

    always_comb begin
        out_valid = v3_q;
        F         = f_q;
        occupancy = {1'b0, v1_q} + {1'b0, v2_q} + {1'b0, v3_q};
    end

endmodule

// File: tb/tb_pipe_ex_hs.sv
// tb/tb_pipe_ex_hs.sv - directed and scoreboard bench for pipe_ex_hs
module tb_pipe_ex_hs;

    localparam int N     = 10;
    localparam int OUT_W = 2*N;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic [N-1:0]     A, B, C, D;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] F;
    logic [1:0]       occupancy;

    int errors = 0;
    int checks = 0;
    int n_out  = 0;
    logic [OUT_W-1:0] exp_q[$];

    pipe_ex_hs #(.N(N), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .F         (F),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                               input logic [N-1:0] c, input logic [N-1:0] d,
                                               input logic m);
        logic [N-1:0]   x1, x2, x3;
        logic [2*N-1:0] p;
        x1 = a + b;
        x2 = m ? (c + d) : (c - d);
        x3 = x1 + x2;
        p  = {{N{1'b0}}, x3} * {{N{1'b0}}, d};
        return p[OUT_W-1:0];
    endfunction

    task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] c, input logic [N-1:0] d, input logic m);
        A = a; B = b; C = c; D = d; mode = m;
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic cycle(output logic acc);
        logic fl;
        #1;
        check("occ_vs_model", occupancy, exp_q.size());
        fl  = flush;
        acc = in_valid && in_ready && !flush;
        if (!fl && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", 1, 0);
            else check("sb_F", F, exp_q.pop_front());
            n_out++;
        end
        if (acc) exp_q.push_back(model(A, B, C, D, mode));
        @(posedge clk);
        if (fl) exp_q.delete();
        @(negedge clk);
    endtask

    // Single transaction through an empty pipe, checking exact latency.
    task automatic run_one(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] c, input logic [N-1:0] d, input logic m,
                           input logic [OUT_W-1:0] exp_f);
        drive(a, b, c, d, m);
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_e1_valid"}, out_valid, 0);
        check({tag, "_e1_occ"}, occupancy, 1);
        @(posedge clk); @(negedge clk);
        check({tag, "_e2_valid"}, out_valid, 0);
        @(posedge clk); @(negedge clk);
        check({tag, "_e3_valid"}, out_valid, 1);
        check({tag, "_F"}, F, exp_f);
        @(posedge clk); @(negedge clk);
        check({tag, "_after_valid"}, out_valid, 0);
        check({tag, "_after_occ"}, occupancy, 0);
    endtask

    logic [N-1:0] ta[5] = '{10'd5,    10'd5, 10'd1000, 10'd7,  10'd1023};
    logic [N-1:0] tb[5] = '{10'd3,    10'd3, 10'd100,  10'd9,  10'd1023};
    logic [N-1:0] tc[5] = '{10'd20,   10'd20, 10'd0,   10'd50, 10'd1023};
    logic [N-1:0] td[5] = '{10'd4,    10'd4, 10'd1,    10'd3,  10'd1023};
    logic         tm[5] = '{1'b0,     1'b1,  1'b0,     1'b1,   1'b0};

    initial begin
        logic acc;
        logic [OUT_W-1:0] hold_f;
        int fed, out0, cyc;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive('0, '0, '0, '0, 1'b0);
        @(posedge clk); @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_F", F, 0);
        check("rst_occ", occupancy, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        run_one("sub", 10'd5, 10'd3, 10'd20, 10'd4, 1'b0, 20'd96);
        run_one("add", 10'd5, 10'd3, 10'd20, 10'd4, 1'b1, 20'd128);
        run_one("wrap", 10'd1000, 10'd100, 10'd0, 10'd1, 1'b0, 20'd75);
        run_one("full", 10'd0, 10'd0, 10'd1022, 10'd1023, 1'b0, 20'd1046529);
        run_one("add2", 10'd7, 10'd9, 10'd50, 10'd3, 1'b1, 20'd207);
        run_one("max", 10'd1023, 10'd1023, 10'd1023, 10'd1023, 1'b0, 20'd1045506);

        // Backpressure: five queued, only three fit until the consumer wakes.
        out_ready = 1'b0; fed = 0; out0 = n_out;
        for (int i = 0; i < 8; i++) begin
            drive(ta[fed % 5], tb[fed % 5], tc[fed % 5], td[fed % 5], tm[fed % 5]);
            in_valid = (fed < 5);
            cycle(acc);
            if (acc) fed++;
        end
        #1;
        check("bp_fed", fed, 3);
        check("bp_occ", occupancy, 3);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_F_head", F, 20'd96);
        hold_f = F;
        @(negedge clk);
        cycle(acc);
        cycle(acc);
        check("bp_F_held", F, hold_f);
        check("bp_valid_held", out_valid, 1);
        out_ready = 1'b1; cyc = 0;
        while ((fed < 5 || exp_q.size() != 0) && cyc < 30) begin
            drive(ta[fed % 5], tb[fed % 5], tc[fed % 5], td[fed % 5], tm[fed % 5]);
            in_valid = (fed < 5);
            cycle(acc);
            if (acc) fed++;
            cyc++;
        end
        in_valid = 1'b0;
        check("bp_drained", exp_q.size(), 0);
        check("bp_out_count", n_out - out0, 5);

        // Random handshake traffic against the scoreboard.
        fed = 0; cyc = 0; out0 = n_out;
        while (fed < 1000 && cyc < 20000) begin
            drive(N'($urandom), N'($urandom), N'($urandom), N'($urandom), 1'($urandom));
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            cycle(acc);
            if (acc) fed++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle(acc);
        check("rnd_fed", fed, 1000);
        check("rnd_drained", exp_q.size(), 0);
        check("rnd_out_count", n_out - out0, 1000);

        // Flush a full pipe while input is offered.
        out_ready = 1'b0; in_valid = 1'b1;
        drive(10'd5, 10'd3, 10'd20, 10'd4, 1'b0);
        for (int i = 0; i < 5; i++) cycle(acc);
        check("fl_pre_occ", occupancy, 3);
        flush = 1'b1;
        cycle(acc);
        flush = 1'b0; in_valid = 1'b0;
        check("fl_occ", occupancy, 0);
        check("fl_out_valid", out_valid, 0);
        // Flush with in_ready high must still discard the offered input.
        in_valid = 1'b1; flush = 1'b1;
        #1;
        check("fl2_in_ready", in_ready, 1);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("fl2_occ", occupancy, 0);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check("fl2_no_leak", out_valid, 0);
        run_one("post_fl", 10'd5, 10'd3, 10'd20, 10'd4, 1'b1, 20'd128);

        // Asynchronous reset in the middle of a stream.
        out_ready = 1'b0; in_valid = 1'b1;
        drive(10'd7, 10'd9, 10'd50, 10'd3, 1'b1);
        for (int i = 0; i < 4; i++) cycle(acc);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_F", F, 0);
        check("arst_occ", occupancy, 0);
        exp_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_occ_after", occupancy, 0);
        @(negedge clk);
        run_one("post_rst", 10'd1000, 10'd100, 10'd0, 10'd1, 1'b0, 20'd75);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
